// File: rtl/bus_pkg_ysyx_24100029.sv
// Shared types for the IFU/LSU data-memory arbiter.
// Optional feature macro: ARB_RR_EN (round-robin tie break; fixed LSU priority otherwise).
package bus_pkg_ysyx_24100029;

    localparam int ADDR_W_DEFAULT  = 32;
    localparam int DATA_W_DEFAULT  = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Pick the master to serve; only meaningful when at least one is requesting.
    // A lone requester always wins; a tie goes to the LSU, or, with round-robin,
    // to whichever master was not served last.
    function automatic owner_e pick_winner(input logic   ifu_v,
                                           input logic   lsu_v,
                                           input owner_e last);
        owner_e w;
        if (ifu_v && lsu_v) begin
`ifdef ARB_RR_EN
            w = (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
`else
            w = OWN_LSU;
`endif
        end else if (lsu_v) begin
            w = OWN_LSU;
        end else begin
            w = OWN_IFU;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_timer_ysyx_24100029.sv
// Saturating transaction timer: clear wins over enable, the count stops at MAX
// and expired stays high from then on until the next clear.
module arb_timer_ysyx_24100029 #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear to zero, otherwise step while enabled and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == MAX_C);

endmodule

// File: rtl/bus_arbiter_ysyx_24100029.sv
// Arbiter sharing one memory port between IFU (read-only) and LSU.
// One transaction in flight: IDLE (arbitrate) -> ISSUE -> WAIT -> RESP -> IDLE.
// A stalled memory is turned into an error response by the timer; the timer is
// cleared in IDLE, counts in ISSUE/WAIT, and when it reads TIMEOUT the next edge
// goes to RESP (unless the request handshake happens in that same ISSUE cycle).
// Optional feature macro: ARB_RR_EN (see bus_pkg_ysyx_24100029::pick_winner).
module bus_arbiter_ysyx_24100029
    import bus_pkg_ysyx_24100029::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    // IFU master
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    // LSU master
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    // Memory slave
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q,      state_d;
    owner_e              owner_q,      owner_d;
    owner_e              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic                wen_q,        wen_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [STRB_W-1:0]   wstrb_q,      wstrb_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    logic                rsp_err_q,    rsp_err_d;

    owner_e winner;
    logic   any_req;
    logic   timer_expired;

    assign any_req = ifu_req_valid | lsu_req_valid;
    assign winner  = pick_winner(ifu_req_valid, lsu_req_valid, last_grant_q);

    arb_timer_ysyx_24100029 #(
        .MAX (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == IDLE),
        .enable  ((state_q == ISSUE) || (state_q == WAIT)),
        .expired (timer_expired)
    );

    // FSM next state plus request/response latches.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    if (winner == OWN_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wstrb_d = lsu_wstrb;
                    end else begin
                        // Instruction fetch is always a plain read.
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The handshake takes precedence over an expiring timer.
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timer_expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_data_d = wen_q ? '0 : mem_rsp_data;
                    rsp_err_d  = mem_rsp_err;
                    state_d    = RESP;
                end else if (timer_expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Accept pulses are combinational in IDLE; rst_n keeps them low during reset.
    assign ifu_req_ready = rst_n && (state_q == IDLE) && ifu_req_valid && (winner == OWN_IFU);
    assign lsu_req_ready = rst_n && (state_q == IDLE) && lsu_req_valid && (winner == OWN_LSU);

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

    // Only the owner sees the response; the other side reads all zeros.
    assign ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rsp_data  = ifu_rsp_valid ? rsp_data_q : '0;
    assign ifu_rsp_err   = ifu_rsp_valid & rsp_err_q;
    assign lsu_rsp_data  = lsu_rsp_valid ? rsp_data_q : '0;
    assign lsu_rsp_err   = lsu_rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_bus_arbiter_ysyx_24100029.sv
// Directed bench for bus_arbiter_ysyx_24100029 (TIMEOUT=8).
// Inputs change 1ns after a rising edge; outputs are sampled 2ns later.
module tb_bus_arbiter_ysyx_24100029;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk;
    logic          rst_n;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wstrb;
    logic          lsu_rsp_valid, lsu_rsp_err;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_rsp_valid, mem_rsp_err;
    logic [DW-1:0] mem_rsp_data;

    int   checks_total  = 0;
    int   checks_passed = 0;
    logic flag;

    bus_arbiter_ysyx_24100029 #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wstrb     (lsu_wstrb),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait transaction: accept at t, ISSUE at t+1, memory answers at t+2,
    // owner response at t+3. The losing master (if any) keeps requesting.
    task automatic txn(input string tag, input logic iv, input logic lv, input logic exp_lsu,
                       input logic [31:0] rdata, input logic rerr);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_wen;
        logic        other_seen;
        exp_addr   = exp_lsu ? lsu_addr : ifu_addr;
        exp_wen    = exp_lsu ? lsu_wen : 1'b0;
        exp_data   = (exp_lsu && lsu_wen) ? 32'h0 : rdata;
        other_seen = 1'b0;
        // t: accept
        next_cycle();
        ifu_req_valid = iv;
        lsu_req_valid = lv;
        mem_req_ready = 1'b1;
        #2;
        check_eq({tag, "_idle_rsp"}, {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        check_eq({tag, "_ifu_rdy"}, ifu_req_ready, !exp_lsu);
        check_eq({tag, "_lsu_rdy"}, lsu_req_ready, exp_lsu);
        // t+1: ISSUE
        next_cycle();
        if (exp_lsu) lsu_req_valid = 1'b0;
        else         ifu_req_valid = 1'b0;
        #2;
        check_eq({tag, "_issue"}, {mem_req_valid, mem_wen}, {1'b1, exp_wen});
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_busy_rdy"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
        other_seen = other_seen | ifu_rsp_valid | lsu_rsp_valid;
        // t+2: WAIT, memory answers
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata;
        mem_rsp_err   = rerr;
        #2;
        check_eq({tag, "_wait_req"}, mem_req_valid, 1'b0);
        other_seen = other_seen | ifu_rsp_valid | lsu_rsp_valid;
        // t+3: RESP
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        #2;
        if (exp_lsu) begin
            check_eq({tag, "_rsp"}, {lsu_rsp_valid, lsu_rsp_err}, {1'b1, rerr});
            check_eq({tag, "_data"}, lsu_rsp_data, exp_data);
            other_seen = other_seen | ifu_rsp_valid;
        end else begin
            check_eq({tag, "_rsp"}, {ifu_rsp_valid, ifu_rsp_err}, {1'b1, rerr});
            check_eq({tag, "_data"}, ifu_rsp_data, exp_data);
            other_seen = other_seen | lsu_rsp_valid;
        end
        check_eq({tag, "_other"}, other_seen, 1'b0);
        $display("txn %s owner=%s addr=0x%08h data=0x%08h", tag, exp_lsu ? "LSU" : "IFU",
                 exp_addr, exp_data);
    endtask

    initial begin
        rst_n         = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wstrb     = 4'h0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;

        // Reset: every output low even with both masters requesting.
        #12;
        check_eq("reset_ctl", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                               mem_req_valid, mem_wen, ifu_rsp_err, lsu_rsp_err}, 8'h00);
        check_eq("reset_addr", mem_addr, 32'h0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #6;
        rst_n = 1'b1;

        // 1: IFU read, zero-wait memory.
        txn("ifu_read", 1'b1, 1'b0, 1'b0, 32'h0010_0073, 1'b0);

        // 2: both request every time.
        ifu_addr = 32'h8000_0004;
        txn("arb1", 1'b1, 1'b1, 1'b1, 32'h1111_0001, 1'b0);
`ifdef ARB_RR_EN
        txn("arb2", 1'b1, 1'b1, 1'b0, 32'h2222_0002, 1'b0);
`else
        txn("arb2", 1'b1, 1'b1, 1'b1, 32'h2222_0002, 1'b0);
`endif
        txn("arb3", 1'b1, 1'b1, 1'b1, 32'h3333_0003, 1'b0);
        ifu_req_valid = 1'b0;

        // 3: LSU write held in ISSUE for 3 cycles; master inputs change after accept.
        next_cycle();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wstrb     = 4'hF;
        mem_req_ready = 1'b0;
        #2;
        check_eq("wr_rdy", lsu_req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            lsu_req_valid = 1'b0;
            lsu_addr      = 32'h0;
            lsu_wdata     = 32'h0;
            lsu_wstrb     = 4'h0;
            #2;
            check_eq("wr_hold", {mem_req_valid, mem_wen, mem_wstrb, mem_addr, mem_wdata},
                     {1'b1, 1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF});
        end
        next_cycle();
        mem_req_ready = 1'b1;
        #2;
        check_eq("wr_issue", mem_req_valid, 1'b1);
        next_cycle();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        #2;
        check_eq("wr_wait", {mem_req_valid, lsu_rsp_valid}, 2'b00);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check_eq("wr_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b100);
        check_eq("wr_data", lsu_rsp_data, 32'h0);
        $display("txn wr owner=LSU addr=0x80000100 data=0x00000000");
        lsu_wen = 1'b0;

        // 4: memory accepts but never answers; timer reads TIMEOUT in the 8th WAIT cycle.
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        mem_req_ready = 1'b1;
        #2;
        next_cycle();
        ifu_req_valid = 1'b0;
        #2;
        check_eq("tmo_issue", mem_req_valid, 1'b1);
        flag = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            next_cycle();
            mem_req_ready = 1'b0;
            #2;
            flag = flag | ifu_rsp_valid | lsu_rsp_valid;
        end
        check_eq("tmo_early", flag, 1'b0);
        next_cycle();
        #2;
        check_eq("tmo_rsp", {ifu_rsp_valid, ifu_rsp_err}, 2'b11);
        check_eq("tmo_data", ifu_rsp_data, 32'h0);
        $display("txn timeout owner=IFU addr=0x80000080 err=1");
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hAAAA_5555;
        #2;
        check_eq("tmo_late0", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check_eq("tmo_late1", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);

        // 4b: handshake in the same ISSUE cycle the timer reads TIMEOUT -> WAIT, then timeout.
        next_cycle();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0300;
        mem_req_ready = 1'b0;
        #2;
        flag = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            next_cycle();
            lsu_req_valid = 1'b0;
            #2;
            flag = flag | lsu_rsp_valid | !mem_req_valid;
        end
        check_eq("race_stall", flag, 1'b0);
        next_cycle();
        mem_req_ready = 1'b1;
        #2;
        check_eq("race_issue", mem_req_valid, 1'b1);
        next_cycle();
        mem_req_ready = 1'b0;
        #2;
        check_eq("race_wait", {mem_req_valid, lsu_rsp_valid}, 2'b00);
        next_cycle();
        #2;
        check_eq("race_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b11);
        $display("txn race owner=LSU addr=0x80000300 err=1");

        // 5: reset asserted while in WAIT.
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        mem_req_ready = 1'b1;
        #2;
        next_cycle();
        ifu_req_valid = 1'b0;
        #2;
        next_cycle();
        ifu_req_valid = 1'b1;
        #2;
        check_eq("rst_pre", {mem_req_valid, mem_addr}, {1'b0, 32'h8000_0040});
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_ctl", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                   mem_req_valid}, 5'h00);
        check_eq("rst_async_addr", mem_addr, 32'h0);
        ifu_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        ifu_addr = 32'h8000_0044;
        txn("post_rst", 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);

        // 6: slave error on an LSU read.
        lsu_addr = 32'h8000_0400;
        lsu_wen  = 1'b0;
        txn("lsu_err", 1'b0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);

        next_cycle();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
